stream_pkt_arbiter: RTL and testbench

//  Packet-aware round-robin arbiter that merges NUM_SRC stream FIFOs (fall-through read:

---
 rtl/stream_pkt_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_stream_pkt_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// stream_pkt_arbiter
//   Packet-aware round-robin arbiter. Merges NUM_SRC fall-through stream FIFOs
//   into one registered valid/ready stream. A grant is held for a whole packet,
//   so packets from different sources never interleave on the output. Packets
//   longer than MAX_BEATS are cut short: beat MAX_BEATS is sent with out_last
//   forced high, and the rest of that packet is popped and thrown away.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   src_empty      per-source FIFO empty
//   src_rd_en      per-source pop strobe (combinational, at most one hot)
//   src_data       flattened head data, source i at [i*WIDTH +: WIDTH]
//   src_keep       flattened head keep, source i at [i*KEEP_W +: KEEP_W]
//   src_last       per-source head beat is last of its packet
//   out_valid      output beat valid (registered)
//   out_ready      downstream accept
//   out_data       output beat data
//   out_keep       output byte enables
//   out_last       last beat of packet (natural or forced)
//   out_src        source index of the current beat
//   err_oversize   one-cycle pulse when a packet is truncated
// ---------------------------------------------------------------------------
module stream_pkt_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int WIDTH     = 256,
  parameter int KEEP_W    = 32,
  parameter int MAX_BEATS = 64,
  localparam int SRC_W    = $clog2(NUM_SRC),
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_empty,
  output logic [NUM_SRC-1:0]        src_rd_en,
  input  logic [NUM_SRC*WIDTH-1:0]  src_data,
  input  logic [NUM_SRC*KEEP_W-1:0] src_keep,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [KEEP_W-1:0]         out_keep,
  output logic                      out_last,
  output logic [SRC_W-1:0]          out_src,
  output logic                      err_oversize
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [SRC_W-1:0]    grant_r;
  logic [SRC_W-1:0]    rr_ptr_r;
  logic [CNT_W-1:0]    beat_cnt_r;

  logic                out_valid_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [KEEP_W-1:0]   out_keep_r;
  logic                out_last_r;
  logic [SRC_W-1:0]    out_src_r;
  logic                err_r;

  logic [WIDTH-1:0]    data_arr_s [NUM_SRC];
  logic [KEEP_W-1:0]   keep_arr_s [NUM_SRC];
  logic [WIDTH-1:0]    head_data_s;
  logic [KEEP_W-1:0]   head_keep_s;
  logic                head_last_s;
  logic                head_empty_s;
  logic [SRC_W:0]      pick_s;
  logic                pick_valid_s;
  logic [SRC_W-1:0]    pick_idx_s;
  logic                can_load_s;
  logic                pop_s;
  logic                load_s;
  logic                at_max_s;

  // First non-empty source after ptr, wrapping modulo NUM_SRC; MSB = found.
  function automatic logic [SRC_W:0] rr_pick(input logic [SRC_W-1:0]   ptr,
                                              input logic [NUM_SRC-1:0] empty);
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] sel;
    logic             found;
    logic             hit;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx   = SRC_W'((int'(ptr) + k) % NUM_SRC);
      hit   = !found && !empty[idx];
      sel   = hit ? idx : sel;
      found = found | hit;
    end
    return {found, sel};
  endfunction

  // Unflatten the per-source head buses so the granted one can be indexed.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unflat
    assign data_arr_s[g] = src_data[g*WIDTH +: WIDTH];
    assign keep_arr_s[g] = src_keep[g*KEEP_W +: KEEP_W];
  end

  assign head_data_s  = data_arr_s[grant_r];
  assign head_keep_s  = keep_arr_s[grant_r];
  assign head_last_s  = src_last[grant_r];
  assign head_empty_s = src_empty[grant_r];

  assign pick_s       = rr_pick(rr_ptr_r, src_empty);
  assign pick_valid_s = pick_s[SRC_W];
  assign pick_idx_s   = pick_s[SRC_W-1:0];

  assign can_load_s   = !out_valid_r || out_ready;
  // Beat count before this pop equals MAX_BEATS-1: this pop is beat MAX_BEATS.
  assign at_max_s     = (beat_cnt_r == CNT_W'(MAX_BEATS - 1));
  assign load_s       = (state_r == ST_BUSY) && pop_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (pop_s && head_last_s) begin
          state_nxt_s = ST_IDLE;
        end else if (pop_s && at_max_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: pop strobe for the granted source only. DRAIN ignores
  // out_ready because discarded beats never touch the output register.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_BUSY:  pop_s = !head_empty_s && can_load_s;
      ST_DRAIN: pop_s = !head_empty_s;
      default:  pop_s = 1'b0;
    endcase
    src_rd_en = pop_s ? (NUM_SRC'(1'b1) << grant_r) : {NUM_SRC{1'b0}};
  end

  // Grant, round-robin pointer and per-packet beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r    <= '0;
      rr_ptr_r   <= SRC_W'(NUM_SRC - 1);
      beat_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && pick_valid_s) begin
      grant_r    <= pick_idx_s;
      beat_cnt_r <= '0;
    end else if (load_s) begin
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      if (head_last_s || at_max_s) begin
        rr_ptr_r <= grant_r;
      end
    end
  end

  // Output register and truncation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_keep_r  <= '0;
      out_last_r  <= 1'b0;
      out_src_r   <= '0;
      err_r       <= 1'b0;
    end else begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= head_data_s;
        out_keep_r  <= head_keep_s;
        out_last_r  <= head_last_s || at_max_s;
        out_src_r   <= grant_r;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      // A natural last on beat MAX_BEATS is a legal packet, not a truncation.
      err_r <= load_s && at_max_s && !head_last_s;
    end
  end

  assign out_valid    = out_valid_r;
  assign out_data     = out_data_r;
  assign out_keep     = out_keep_r;
  assign out_last     = out_last_r;
  assign out_src      = out_src_r;
  assign err_oversize = err_r;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_pkt_arbiter
//   Directed bench for stream_pkt_arbiter (NUM_SRC=4, WIDTH=16, KEEP_W=2,
//   MAX_BEATS=4). Source FIFOs are modelled as queues; accepted output beats
//   are logged and compared against hand-written expectation tables.
//   Beat data encoding: {src[3:0], pkt[3:0], beat[7:0]}.
// ---------------------------------------------------------------------------
module tb_stream_pkt_arbiter;

  localparam int NS = 4;
  localparam int W  = 16;
  localparam int KW = 2;
  localparam int MB = 4;
  localparam int SW = 2;

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     src_empty;
  logic [NS-1:0]     src_rd_en;
  logic [NS*W-1:0]   src_data;
  logic [NS*KW-1:0]  src_keep;
  logic [NS-1:0]     src_last;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [KW-1:0]     out_keep;
  logic              out_last;
  logic [SW-1:0]     out_src;
  logic              err_oversize;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int            src;
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } vec_t;

  typedef struct {
    int            src;
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } obs_t;

  beat_t         fifo_q [NS][$];
  obs_t          out_log [$];
  vec_t          exp_q [$];

  int            n_checks;
  int            n_errors;
  int            cyc;
  int            err_pulses;
  int            err_cyc;
  int            t0;
  logic          smp_valid;
  logic [W-1:0]  smp_data;
  logic [NS-1:0] smp_rd_en;

  stream_pkt_arbiter #(
    .NUM_SRC   (NS),
    .WIDTH     (W),
    .KEEP_W    (KW),
    .MAX_BEATS (MB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_empty    (src_empty),
    .src_rd_en    (src_rd_en),
    .src_data     (src_data),
    .src_keep     (src_keep),
    .src_last     (src_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .out_src      (out_src),
    .err_oversize (err_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk_data(input int s, input int p, input int b);
    return {4'(s), 4'(p), 8'(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      if (fifo_q[i].size() == 0) begin
        src_empty[i]            = 1'b1;
        src_data[i*W +: W]      = '0;
        src_keep[i*KW +: KW]    = '0;
        src_last[i]             = 1'b0;
      end else begin
        src_empty[i]            = 1'b0;
        src_data[i*W +: W]      = fifo_q[i][0].data;
        src_keep[i*KW +: KW]    = fifo_q[i][0].keep;
        src_last[i]             = fifo_q[i][0].last;
      end
    end
  endtask

  task automatic push_pkt(input int s, input int p, input int n);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt.data = mk_data(s, p, b);
      bt.keep = (b == n - 1) ? 2'b01 : 2'b11;
      bt.last = (b == n - 1);
      fifo_q[s].push_back(bt);
    end
    drive_inputs();
  endtask

  task automatic add_exp(input int s, input int p, input int b, input logic [KW-1:0] k, input logic l);
    vec_t v;
    v.src  = s;
    v.data = mk_data(s, p, b);
    v.keep = k;
    v.last = l;
    exp_q.push_back(v);
  endtask

  // One clock: sample outputs on the falling edge, then apply pops and new
  // FIFO heads 1 time unit after the rising edge.
  task automatic tick();
    obs_t o;
    @(negedge clk);
    smp_valid = out_valid;
    smp_data  = out_data;
    smp_rd_en = src_rd_en;
    n_checks++;
    if ($countones(src_rd_en) > 1 || (src_rd_en & src_empty) != '0) begin
      n_errors++;
      $display("FAIL rd_en_protocol: rd_en=%b empty=%b, required at most one hot and none on empty",
               src_rd_en, src_empty);
    end
    if (err_oversize) begin
      err_pulses++;
      err_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      o.src  = int'(out_src);
      o.data = out_data;
      o.keep = out_keep;
      o.last = out_last;
      o.cyc  = cyc;
      out_log.push_back(o);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NS; i++) begin
      if (smp_rd_en[i] && fifo_q[i].size() > 0) begin
        void'(fifo_q[i].pop_front());
      end
    end
    drive_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (out_log.size() < n && t < budget) begin
      tick();
      t++;
    end
    check(name, 32'(out_log.size() >= n), 32'd1);
  endtask

  task automatic compare_log(input string name);
    check({name, "_count"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++) begin
      check($sformatf("%s_src[%0d]", name, i),  32'(out_log[i].src), 32'(exp_q[i].src));
      check($sformatf("%s_data[%0d]", name, i), 32'(out_log[i].data), 32'(exp_q[i].data));
      check($sformatf("%s_keep[%0d]", name, i), 32'(out_log[i].keep), 32'(exp_q[i].keep));
      check($sformatf("%s_last[%0d]", name, i), 32'(out_log[i].last), 32'(exp_q[i].last));
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NS; i++) fifo_q[i].delete();
    drive_inputs();
    idle(2);
    rst_n = 1'b1;
    out_log.delete();
    exp_q.delete();
    err_pulses = 0;
    err_cyc    = -1;
  endtask

  initial begin
    vec_t stim [8];
    n_checks   = 0;
    n_errors   = 0;
    cyc        = 0;
    err_pulses = 0;
    err_cyc    = -1;
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    src_empty  = '1;
    src_data   = '0;
    src_keep   = '0;
    src_last   = '0;
    drive_inputs();

    // Reset values
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err_oversize), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_keep", 32'(out_keep), 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_rd_en", 32'(src_rd_en), 32'd0);

    // 1: single 3-beat packet on src0, one arbitration bubble, 2-cycle latency
    do_reset();
    t0 = cyc;
    push_pkt(0, 1, 3);
    add_exp(0, 1, 0, 2'b11, 1'b0);
    add_exp(0, 1, 1, 2'b11, 1'b0);
    add_exp(0, 1, 2, 2'b01, 1'b1);
    wait_beats(3, 20, "t1_timeout");
    idle(3);
    compare_log("t1");
    if (out_log.size() >= 3) begin
      check("t1_latency_b0", 32'(out_log[0].cyc), 32'(t0 + 2));
      check("t1_latency_b1", 32'(out_log[1].cyc), 32'(t0 + 3));
      check("t1_latency_b2", 32'(out_log[2].cyc), 32'(t0 + 4));
    end else begin
      check("t1_latency_log", 32'(out_log.size()), 32'd3);
    end
    check("t1_err_pulses", 32'(err_pulses), 32'd0);
    check("t1_idle_valid", 32'(out_valid), 32'd0);

    // 2: two 1-beat packets per source, round-robin with wrap (table-driven)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      stim[i].src  = i % 4;
      stim[i].data = mk_data(i % 4, 2 + i / 4, 0);
      stim[i].keep = 2'b01;
      stim[i].last = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      fifo_q[stim[i].src].push_back('{stim[i].data, stim[i].keep, stim[i].last});
    end
    drive_inputs();
    for (int i = 0; i < 8; i++) exp_q.push_back(stim[i]);
    wait_beats(8, 60, "t2_timeout");
    idle(3);
    compare_log("t2");
    check("t2_err_pulses", 32'(err_pulses), 32'd0);

    // 3: backpressure with beat 2 held for 5 cycles; 4-beat packet (= MAX_BEATS, natural last)
    do_reset();
    push_pkt(1, 3, 4);
    for (int b = 0; b < 4; b++) add_exp(1, 3, b, (b == 3) ? 2'b01 : 2'b11, b == 3);
    wait_beats(1, 20, "t3_timeout_b0");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_stall_valid[%0d]", i), 32'(smp_valid), 32'd1);
      check($sformatf("t3_stall_data[%0d]", i), 32'(smp_data), 32'(mk_data(1, 3, 1)));
      check($sformatf("t3_stall_rd_en[%0d]", i), 32'(smp_rd_en), 32'd0);
    end
    out_ready = 1'b1;
    wait_beats(4, 20, "t3_timeout");
    idle(3);
    compare_log("t3");
    check("t3_err_pulses", 32'(err_pulses), 32'd0);
    check("t3_fifo_left", 32'(fifo_q[1].size()), 32'd0);

    // 4: src0/src3 arrive while src2 is mid-packet
    do_reset();
    push_pkt(2, 4, 3);
    wait_beats(1, 20, "t4_timeout_b0");
    push_pkt(0, 5, 1);
    push_pkt(3, 6, 1);
    add_exp(2, 4, 0, 2'b11, 1'b0);
    add_exp(2, 4, 1, 2'b11, 1'b0);
    add_exp(2, 4, 2, 2'b01, 1'b1);
    add_exp(3, 6, 0, 2'b01, 1'b1);
    add_exp(0, 5, 0, 2'b01, 1'b1);
    wait_beats(5, 30, "t4_timeout");
    idle(3);
    compare_log("t4");

    // 5: 6-beat packet truncated at MAX_BEATS=4, then next rr source
    do_reset();
    push_pkt(1, 7, 6);
    push_pkt(1, 8, 1);
    push_pkt(2, 9, 1);
    add_exp(1, 7, 0, 2'b11, 1'b0);
    add_exp(1, 7, 1, 2'b11, 1'b0);
    add_exp(1, 7, 2, 2'b11, 1'b0);
    add_exp(1, 7, 3, 2'b11, 1'b1);
    add_exp(2, 9, 0, 2'b01, 1'b1);
    add_exp(1, 8, 0, 2'b01, 1'b1);
    wait_beats(6, 40, "t5_timeout");
    idle(3);
    compare_log("t5");
    check("t5_err_pulses", 32'(err_pulses), 32'd1);
    if (out_log.size() >= 4) begin
      check("t5_err_with_beat4", 32'(err_cyc), 32'(out_log[3].cyc));
    end else begin
      check("t5_err_log", 32'(out_log.size()), 32'd6);
    end
    check("t5_fifo1_left", 32'(fifo_q[1].size()), 32'd0);

    // 6: asynchronous reset during beat 2; leftover beat resumes as a new packet
    do_reset();
    push_pkt(0, 10, 3);
    wait_beats(1, 20, "t6_timeout_b0");
    push_pkt(1, 11, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_rd_en", 32'(src_rd_en), 32'd0);
    check("t6_async_last", 32'(out_last), 32'd0);
    out_log.delete();
    idle(2);
    rst_n = 1'b1;
    add_exp(0, 10, 2, 2'b01, 1'b1);
    add_exp(1, 11, 0, 2'b01, 1'b1);
    wait_beats(2, 20, "t6_timeout");
    idle(3);
    compare_log("t6");
    check("t6_fifo0_left", 32'(fifo_q[0].size()), 32'd0);
    check("t6_fifo1_left", 32'(fifo_q[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
